// File: rtl/vga_scan_gen_if.sv
// rtl/vga_scan_gen_if.sv - endpoint update handshake between game logic and scan generator
interface vga_scan_gen_if;
    logic       upd_valid;
    logic [9:0] upd_x1;
    logic [9:0] upd_y1;
    logic [9:0] upd_x2;
    logic [9:0] upd_y2;
    logic       upd_ready;

    modport master (
        output upd_valid,
        output upd_x1,
        output upd_y1,
        output upd_x2,
        output upd_y2,
        input  upd_ready
    );

    modport slave (
        input  upd_valid,
        input  upd_x1,
        input  upd_y1,
        input  upd_x2,
        input  upd_y2,
        output upd_ready
    );
endinterface

// File: rtl/vga_scan_gen.sv
// rtl/vga_scan_gen.sv - raster scan generator with frame-committed line endpoints
module vga_scan_gen #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic           clk,
    input  logic           rst,
    vga_scan_gen_if.slave  upd,
    output logic [9:0]     x,
    output logic [9:0]     y,
    output logic           pix_en,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic           frame_rst,
    output logic [9:0]     x1,
    output logic [9:0]     y1,
    output logic [9:0]     x2,
    output logic [9:0]     y2
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
    localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [9:0] X_VIS  = 10'(H_VIS);
    localparam logic [9:0] Y_VIS  = 10'(V_VIS);
    localparam logic [9:0] X_MAX  = 10'(H_VIS - 1);
    localparam logic [9:0] Y_MAX  = 10'(V_VIS - 1);

    logic       ph;
    logic [9:0] x_nxt;
    logic [9:0] y_nxt;
    logic       commit_edge;
    logic       take;
    logic       pend;
    logic       pend_nxt;
    logic       ready_q;
    logic [9:0] p_x1;
    logic [9:0] p_y1;
    logic [9:0] p_x2;
    logic [9:0] p_y2;

    function automatic logic [9:0] clamp(input logic [9:0] v, input logic [9:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    assign pix_en        = ph;
    assign upd.upd_ready = ready_q;
    assign take          = upd.upd_valid & ready_q;

    // Next scan position; decodes are taken from these so they line up with x/y.
    always_comb begin
        x_nxt = x;
        y_nxt = y;
        if (ph) begin
            if (x == H_LAST) begin
                x_nxt = '0;
                y_nxt = (y == V_LAST) ? '0 : y + 10'd1;
            end else begin
                x_nxt = x + 10'd1;
            end
        end
        commit_edge = ph & (x_nxt == H_LAST) & (y_nxt == V_LAST);
        pend_nxt    = pend;
        if (take) begin
            pend_nxt = 1'b1;
        end else if (commit_edge) begin
            pend_nxt = 1'b0;
        end
    end

    // Pixel divider, scan counters and registered sync/enable decodes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph        <= 1'b0;
            x         <= '0;
            y         <= '0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            de        <= 1'b1;
            frame_rst <= 1'b0;
        end else begin
            ph        <= ~ph;
            x         <= x_nxt;
            y         <= y_nxt;
            hsync     <= !((x_nxt >= HS_BEG) && (x_nxt <= HS_END));
            vsync     <= !((y_nxt >= VS_BEG) && (y_nxt <= VS_END));
            de        <= (x_nxt < X_VIS) && (y_nxt < Y_VIS);
            frame_rst <= (x_nxt == H_LAST) && (y_nxt == V_LAST);
        end
    end

    // Accept one clamped update per frame and commit it on the frame boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend    <= 1'b0;
            ready_q <= 1'b1;
            p_x1    <= '0;
            p_y1    <= '0;
            p_x2    <= '0;
            p_y2    <= '0;
            x1      <= '0;
            y1      <= '0;
            x2      <= '0;
            y2      <= '0;
        end else begin
            pend    <= pend_nxt;
            ready_q <= !pend_nxt;
            if (commit_edge && pend) begin
                x1 <= p_x1;
                y1 <= p_y1;
                x2 <= p_x2;
                y2 <= p_y2;
            end
            if (take) begin
                p_x1 <= clamp(upd.upd_x1, X_MAX);
                p_y1 <= clamp(upd.upd_y1, Y_MAX);
                p_x2 <= clamp(upd.upd_x2, X_MAX);
                p_y2 <= clamp(upd.upd_y2, Y_MAX);
            end
        end
    end

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb/tb_vga_scan_gen.sv - self-checking bench for vga_scan_gen on a reduced raster
module tb_vga_scan_gen;

    localparam int H_VIS  = 20;
    localparam int H_FP   = 2;
    localparam int H_SYNC = 3;
    localparam int H_BP   = 5;
    localparam int V_VIS  = 12;
    localparam int V_FP   = 2;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 3;
    localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FRAME  = 2 * H_TOT * V_TOT;
    localparam int BUDGET = 3000;

    typedef struct {
        logic [9:0] x1;
        logic [9:0] y1;
        logic [9:0] x2;
        logic [9:0] y2;
    } ep_t;

    typedef struct {
        ep_t in;
        ep_t exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] x, y, x1, y1, x2, y2;
    logic       pix_en, hsync, vsync, de, frame_rst;

    vga_scan_gen_if upd_bus ();

    vga_scan_gen #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clk(clk), .rst(rst), .upd(upd_bus),
        .x(x), .y(y), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
        .de(de), .frame_rst(frame_rst),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2)
    );

    always #10 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int edges = 0;
    int raster_bad = 0;
    int hs_cnt = 0, vs_cnt = 0, de_cnt = 0, fr_cnt = 0;
    int m_pos, m_ex, m_ey;
    logic m_hs, m_vs, m_de, m_fr;
    ep_t sb[$];
    ep_t last;

    // Clock edges since reset release; the raster reference is derived from it.
    always @(posedge clk or negedge rst) begin
        if (!rst) edges <= 0;
        else      edges <= edges + 1;
    end

    // Raster reference compared every clk, plus free-running activity counters.
    always @(negedge clk) begin
        m_pos = (edges / 2) % (H_TOT * V_TOT);
        m_ex  = m_pos % H_TOT;
        m_ey  = m_pos / H_TOT;
        m_hs  = !(m_ex >= H_VIS + H_FP && m_ex < H_VIS + H_FP + H_SYNC);
        m_vs  = !(m_ey >= V_VIS + V_FP && m_ey < V_VIS + V_FP + V_SYNC);
        m_de  = (m_ex < H_VIS) && (m_ey < V_VIS);
        m_fr  = (m_ex == H_TOT - 1) && (m_ey == V_TOT - 1);
        if (x !== 10'(m_ex) || y !== 10'(m_ey) || pix_en !== edges[0] ||
            hsync !== m_hs || vsync !== m_vs || de !== m_de || frame_rst !== m_fr)
            raster_bad++;
        if (hsync === 1'b0) hs_cnt++;
        if (vsync === 1'b0) vs_cnt++;
        if (de === 1'b1)    de_cnt++;
        if (frame_rst === 1'b1) fr_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_ep(input string name, input ep_t e);
        check(name, {x1, y1, x2, y2}, {e.x1, e.y1, e.x2, e.y2});
    endtask

    function automatic ep_t mk(input int a, input int b, input int c, input int d);
        ep_t r;
        r.x1 = 10'(a);
        r.y1 = 10'(b);
        r.x2 = 10'(c);
        r.y2 = 10'(d);
        return r;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_pos(input int xv, input int yv, input string name);
        int n = 0;
        while (!(x == 10'(xv) && y == 10'(yv)) && n < BUDGET) begin
            step();
            n++;
        end
        check({name, " reached"}, 64'(x == 10'(xv) && y == 10'(yv)), 64'd1);
    endtask

    task automatic wait_frame_rise(input string name);
        int n = 0;
        while (frame_rst !== 1'b0 && n < BUDGET) begin step(); n++; end
        while (frame_rst !== 1'b1 && n < BUDGET) begin step(); n++; end
        check({name, " frame_rst rise"}, 64'(frame_rst), 64'd1);
    endtask

    task automatic offer(input ep_t v, input int budget, output int waited, output bit ok);
        bit r;
        upd_bus.upd_valid = 1'b1;
        upd_bus.upd_x1 = v.x1;
        upd_bus.upd_y1 = v.y1;
        upd_bus.upd_x2 = v.x2;
        upd_bus.upd_y2 = v.y2;
        waited = 0;
        ok = 1'b0;
        while (!ok && waited < budget) begin
            r = upd_bus.upd_ready;
            step();
            waited++;
            ok = r;
        end
        upd_bus.upd_valid = 1'b0;
    endtask

    task automatic pop_check(input string name);
        ep_t e;
        check({name, " scoreboard nonempty"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_ep(name, e);
            last = e;
        end
    endtask

    initial begin
        vec_t vt[4];
        ep_t  a_ep, b_ep, c_ep, d_ep;
        int   w, e0, hs0, vs0, de0, fr0, n;
        bit   ok;

        vt[0].in = mk(3, 4, 15, 9);       vt[0].exp = mk(3, 4, 15, 9);
        vt[1].in = mk(700, 4, 5, 600);    vt[1].exp = mk(19, 4, 5, 11);
        vt[2].in = mk(19, 11, 20, 12);    vt[2].exp = mk(19, 11, 19, 11);
        vt[3].in = mk(1023, 0, 0, 1023);  vt[3].exp = mk(19, 0, 0, 11);
        last = mk(0, 0, 0, 0);

        upd_bus.upd_valid = 1'b0;
        upd_bus.upd_x1 = '0;
        upd_bus.upd_y1 = '0;
        upd_bus.upd_x2 = '0;
        upd_bus.upd_y2 = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        step();
        step();

        check("reset xy", {x, y}, 20'd0);
        check("reset pix_en", 64'(pix_en), 64'd0);
        check("reset syncs/de", {hsync, vsync, de}, 3'b111);
        check("reset frame_rst", 64'(frame_rst), 64'd0);
        check("reset upd_ready", 64'(upd_bus.upd_ready), 64'd1);
        check_ep("reset endpoints", mk(0, 0, 0, 0));

        rst = 1'b1;
        step();
        check("edge1 x", 64'(x), 64'd0);
        check("edge1 pix_en", 64'(pix_en), 64'd1);
        step();
        check("edge2 x", 64'(x), 64'd1);

        wait_frame_rise("first");
        check("first frame_rst edge", 64'(edges), 64'(2 * (V_TOT * H_TOT - 1)));

        for (int f = 0; f < 2; f++) begin
            e0 = edges; hs0 = hs_cnt; vs0 = vs_cnt; de0 = de_cnt; fr0 = fr_cnt;
            wait_frame_rise("stats");
            check("frame period", 64'(edges - e0), 64'(FRAME));
            check("hsync low clks", 64'(hs_cnt - hs0), 64'(2 * H_SYNC * V_TOT));
            check("vsync low clks", 64'(vs_cnt - vs0), 64'(2 * V_SYNC * H_TOT));
            check("de pixel periods", 64'((de_cnt - de0) / 2), 64'(H_VIS * V_VIS));
            check("frame_rst clks", 64'(fr_cnt - fr0), 64'd2);
        end

        for (int i = 0; i < 4; i++) begin
            wait_pos(0, 5, "vec");
            offer(vt[i].in, 4, w, ok);
            check("vec accepted in 1 cycle", 64'(ok && w == 1), 64'd1);
            check("vec upd_ready low", 64'(upd_bus.upd_ready), 64'd0);
            check_ep("vec endpoints held", last);
            sb.push_back(vt[i].exp);
            wait_frame_rise("vec");
            pop_check("vec committed");
            check("vec upd_ready on commit", 64'(upd_bus.upd_ready), 64'd1);
        end

        a_ep = mk(1, 2, 3, 4);
        b_ep = mk(5, 6, 7, 8);
        wait_pos(0, 3, "bp");
        offer(a_ep, 4, w, ok);
        check("bp A accepted", 64'(ok), 64'd1);
        sb.push_back(a_ep);
        offer(b_ep, BUDGET, w, ok);
        check("bp B accepted", 64'(ok), 64'd1);
        check("bp B stalled", 64'(w > 2), 64'd1);
        check("bp B taken after commit", 64'(frame_rst), 64'd1);
        pop_check("bp A committed");
        check("bp upd_ready low", 64'(upd_bus.upd_ready), 64'd0);
        sb.push_back(b_ep);
        wait_frame_rise("bp");
        pop_check("bp B committed");

        c_ep = mk(9, 10, 11, 1);
        n = 0;
        while (!(pix_en === 1'b1 && x == 10'(H_TOT - 2) && y == 10'(V_TOT - 1)) && n < BUDGET) begin
            step();
            n++;
        end
        check("race setup reached", 64'(pix_en === 1'b1 && x == 10'(H_TOT - 2)), 64'd1);
        upd_bus.upd_x1 = c_ep.x1;
        upd_bus.upd_y1 = c_ep.y1;
        upd_bus.upd_x2 = c_ep.x2;
        upd_bus.upd_y2 = c_ep.y2;
        upd_bus.upd_valid = 1'b1;
        step();
        upd_bus.upd_valid = 1'b0;
        e0 = edges;
        check("race frame_rst", 64'(frame_rst), 64'd1);
        check("race accepted", 64'(upd_bus.upd_ready), 64'd0);
        check_ep("race not committed", last);
        sb.push_back(c_ep);
        wait_frame_rise("race");
        check("race commit delay", 64'(edges - e0), 64'(FRAME));
        pop_check("race committed");

        d_ep = mk(12, 13, 14, 2);
        wait_pos(0, 2, "rst");
        offer(d_ep, 4, w, ok);
        check("rst D accepted", 64'(ok), 64'd1);
        wait_pos(15, 7, "rst");
        rst = 1'b0;
        #1;
        check("midrst xy", {x, y}, 20'd0);
        check("midrst flags", {pix_en, hsync, vsync, de, frame_rst}, 5'b01110);
        check("midrst upd_ready", 64'(upd_bus.upd_ready), 64'd1);
        check_ep("midrst endpoints", mk(0, 0, 0, 0));
        step();
        step();
        check("midrst held x", 64'(x), 64'd0);
        rst = 1'b1;
        step();
        check("post-rst edge1 x", 64'(x), 64'd0);
        step();
        check("post-rst edge2 x", 64'(x), 64'd1);
        wait_frame_rise("post-rst");
        check("post-rst frame_rst edge", 64'(edges), 64'(2 * (V_TOT * H_TOT - 1)));
        check_ep("pending discarded", mk(0, 0, 0, 0));
        check("post-rst upd_ready", 64'(upd_bus.upd_ready), 64'd1);

        check("raster monitor errors", 64'(raster_bad), 64'd0);
        check("scoreboard drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
